// File: rtl/conv_enc_pkg.sv
// Shared types and helpers for the parametrised convolutional encoder.
// Holds the FSM encoding, tap parity function and default code constants.
package conv_enc_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_EMIT,
      S_TAIL
   } state_t;

   localparam int KMAX = 9;
   localparam logic [5:0] GEN_DEFAULT = 6'b101_111;

   function automatic logic parity(
      input logic [KMAX-1:0] gen,
      input logic [KMAX-1:0] v
   );
      return ^(gen & v);
   endfunction

endpackage

`ifndef CONV_ENC_CHECK
`define CONV_ENC_CHECK(c, msg) if (!(c)) $error(msg);
`endif

// File: rtl/conv_enc_serializer.sv
// Serialises one N-bit coded word, skipping punctured positions in zero cycles.
// A one-hot pointer walks the set bits of the word's mask under the out handshake.
module conv_enc_serializer #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] word,
   input  logic [N-1:0] msk,
   input  logic         last,
   input  logic         out_ready,
   output logic         out_bit,
   output logic         out_valid,
   output logic         out_last,
   output logic         word_done
);

   logic [N-1:0] w;
   logic [N-1:0] m;
   logic [N-1:0] sel;
   logic [N-1:0] above;
   logic [N-1:0] nxt;
   logic [N-1:0] first;
   logic         vld;
   logic         lst;

   // unmasked positions strictly above the current pointer
   assign above = m & ~(sel | (sel - N'(1)));
   assign nxt   = above & (~above + N'(1));
   assign first = msk & (~msk + N'(1));

   assign out_valid = vld;
   assign out_bit   = vld & |(w & sel);
   assign out_last  = vld & lst & (above == '0);
   assign word_done = vld & out_ready & (above == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w   <= '0;
         m   <= '0;
         sel <= '0;
         vld <= 1'b0;
         lst <= 1'b0;
      end else if (load) begin
         w   <= word;
         m   <= msk;
         sel <= first;
         lst <= last;
         vld <= 1'b1;
      end else if (vld && out_ready) begin
         if (above == '0) begin
            vld <= 1'b0;
            lst <= 1'b0;
         end else begin
            sel <= nxt;
         end
      end
   end

endmodule

// File: rtl/conv_encoder_param.sv
// Feed-forward convolutional encoder, K/N generic, with puncturing and zero tail.
// Holds the frame FSM, shift register, puncture phase and tail counter.
module conv_encoder_param
   import conv_enc_pkg::*;
#(
   parameter int               K         = 3,
   parameter int               N         = 2,
   parameter logic [N*K-1:0]   GEN       = GEN_DEFAULT,
   parameter bit               TAIL_EN   = 1'b1,
   parameter int               PUNCT_P   = 1,
   parameter logic [N*PUNCT_P-1:0] PUNCT_MSK = '1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_bit,
   input  logic in_valid,
   input  logic in_last,
   output logic in_ready,
   output logic out_bit,
   output logic out_valid,
   output logic out_last,
   input  logic out_ready,
   output logic busy
);

   `CONV_ENC_CHECK(K >= 2 && K <= KMAX, "K must be 2..9")
   `CONV_ENC_CHECK(N >= 1 && N <= 4, "N must be 1..4")
   `CONV_ENC_CHECK(PUNCT_P >= 1 && PUNCT_P <= 8, "PUNCT_P must be 1..8")

   for (genvar p = 0; p < PUNCT_P; p++) begin : g_col
      `CONV_ENC_CHECK(PUNCT_MSK[p*N +: N] != '0, "empty puncture phase")
   end

   state_t       st;
   state_t       st_nxt;
   logic         armed;
   logic [K-2:0] sreg;
   logic [2:0]   ph;
   logic [3:0]   tcnt;
   logic         lseen;

   logic         accept;
   logic         tail_load;
   logic         frame_end;
   logic         load;
   logic         load_u;
   logic         load_last;
   logic         tail_fin;
   logic         word_done;
   logic [K-1:0] v;
   logic [N-1:0] word;
   logic [N-1:0] msk_col;

   always_comb begin
      st_nxt    = st;
      in_ready  = 1'b0;
      accept    = 1'b0;
      tail_load = 1'b0;
      frame_end = 1'b0;
      unique case (st)
         S_IDLE, S_ACCEPT: begin
            in_ready = armed;
            accept   = in_valid & armed;
            if (accept) st_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (word_done) begin
               // next word may be accepted in the cycle the last bit leaves
               if (!lseen) begin
                  in_ready = 1'b1;
                  accept   = in_valid;
                  st_nxt   = in_valid ? S_EMIT : S_ACCEPT;
               end else if (TAIL_EN) begin
                  tail_load = 1'b1;
                  st_nxt    = S_TAIL;
               end else begin
                  frame_end = 1'b1;
                  st_nxt    = S_IDLE;
               end
            end
         end
         S_TAIL: begin
            if (word_done) begin
               if (tcnt != 4'd0) begin
                  tail_load = 1'b1;
               end else begin
                  frame_end = 1'b1;
                  st_nxt    = S_IDLE;
               end
            end
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   // tcnt counts tail words still to load after the current one
   assign tail_fin  = (st == S_EMIT) ? (K == 2) : (tcnt == 4'd1);
   assign load      = accept | tail_load;
   assign load_u    = accept & in_bit;
   assign load_last = accept ? (in_last & ~TAIL_EN) : tail_fin;
   assign v         = {load_u, sreg};
   assign msk_col   = PUNCT_MSK[int'(ph)*N +: N];
   assign busy      = (st != S_IDLE);

   always_comb begin
      word = '0;
      for (int j = 0; j < N; j++) begin
         word[j] = parity(KMAX'(GEN[j*K +: K]), KMAX'(v));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= S_IDLE;
      else       st <= st_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed <= 1'b0;
         sreg  <= '0;
         ph    <= '0;
         tcnt  <= '0;
         lseen <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (accept) lseen <= in_last;
         if (load) begin
            sreg <= v[K-1:1];
            ph   <= (ph == 3'(PUNCT_P-1)) ? 3'd0 : ph + 3'd1;
         end
         if (tail_load) begin
            tcnt <= (st == S_EMIT) ? 4'(K-2) : tcnt - 4'd1;
         end
         if (frame_end) begin
            sreg  <= '0;
            ph    <= '0;
            lseen <= 1'b0;
         end
      end
   end

   conv_enc_serializer #(.N(N)) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .word      (word),
      .msk       (msk_col),
      .last      (load_last),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_last  (out_last),
      .word_done (word_done)
   );

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed and randomised checks of conv_encoder_param in four configurations
// against a convolution-sum reference model.
module tb_conv_encoder_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst;
   logic [3:0] in_bit;
   logic [3:0] in_valid;
   logic [3:0] in_last;
   logic [3:0] out_ready;
   logic [3:0] in_ready;
   logic [3:0] out_bit;
   logic [3:0] out_valid;
   logic [3:0] out_last;
   logic [3:0] busy;

   int checks = 0;
   int errors = 0;

   int          kc[4] = '{3, 3, 7, 3};
   int          nc[4] = '{2, 2, 2, 2};
   int          pc[4] = '{1, 2, 1, 1};
   bit          tl[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
   logic [63:0] gc[4] = '{64'b101_111, 64'b101_111,
                          64'b1011011_1111001, 64'b101_111};
   logic [63:0] mc[4] = '{64'b11, 64'b0111, 64'b11, 64'b11};

   conv_encoder_param u0 (
      .clk(clk), .reset(rst[0]), .in_bit(in_bit[0]), .in_valid(in_valid[0]),
      .in_last(in_last[0]), .in_ready(in_ready[0]), .out_bit(out_bit[0]),
      .out_valid(out_valid[0]), .out_last(out_last[0]),
      .out_ready(out_ready[0]), .busy(busy[0]));

   conv_encoder_param #(.PUNCT_P(2), .PUNCT_MSK(4'b0111)) u1 (
      .clk(clk), .reset(rst[1]), .in_bit(in_bit[1]), .in_valid(in_valid[1]),
      .in_last(in_last[1]), .in_ready(in_ready[1]), .out_bit(out_bit[1]),
      .out_valid(out_valid[1]), .out_last(out_last[1]),
      .out_ready(out_ready[1]), .busy(busy[1]));

   conv_encoder_param #(.K(7), .GEN(14'b1011011_1111001)) u2 (
      .clk(clk), .reset(rst[2]), .in_bit(in_bit[2]), .in_valid(in_valid[2]),
      .in_last(in_last[2]), .in_ready(in_ready[2]), .out_bit(out_bit[2]),
      .out_valid(out_valid[2]), .out_last(out_last[2]),
      .out_ready(out_ready[2]), .busy(busy[2]));

   conv_encoder_param #(.TAIL_EN(1'b0)) u3 (
      .clk(clk), .reset(rst[3]), .in_bit(in_bit[3]), .in_valid(in_valid[3]),
      .in_last(in_last[3]), .in_ready(in_ready[3]), .out_bit(out_bit[3]),
      .out_valid(out_valid[3]), .out_last(out_last[3]),
      .out_ready(out_ready[3]), .busy(busy[3]));

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] q2v(input bit q[$]);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < q.size() && i < 64; i++) r[i] = q[i];
      return r;
   endfunction

   function automatic void s2q(input string s, output bit q[$]);
      q = {};
      for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "1");
   endfunction

   // coded bit j at step n = XOR over taps i of g_j[K-1-i] * u[n-i]
   function automatic void model(input int d, input bit data[$],
                                 output bit q[$]);
      bit u[$];
      bit c;
      q = {};
      u = data;
      if (tl[d]) for (int t = 0; t < kc[d] - 1; t++) u.push_back(1'b0);
      for (int n = 0; n < u.size(); n++) begin
         for (int j = 0; j < nc[d]; j++) begin
            c = 1'b0;
            for (int i = 0; i < kc[d]; i++)
               if (n - i >= 0) c ^= gc[d][j*kc[d] + kc[d] - 1 - i] & u[n-i];
            if (mc[d][(n % pc[d])*nc[d] + j]) q.push_back(c);
         end
      end
   endfunction

   task automatic run(input int d, input bit data[$], input int stall,
                      input int abort_at, output bit got[$],
                      output int lastpos, output int nlast,
                      output int span, output logic bmid);
      int   idx = 0;
      int   cyc = 0;
      int   first = -1;
      bit   stl = 1'b0;
      logic pb = 1'b0;
      logic pl = 1'b0;
      bit   ordy;
      got = {};
      lastpos = -1;
      nlast = 0;
      span = 0;
      bmid = 1'b0;
      while (cyc < 600) begin
         @(posedge clk); #1;
         if (stl)
            chk("hold", {out_valid[d], out_bit[d], out_last[d]},
                {1'b1, pb, pl});
         ordy = (stall == 0) || ($urandom_range(0, 99) >= stall);
         out_ready[d] = ordy;
         in_valid[d]  = (idx < data.size());
         in_bit[d]    = (idx < data.size()) ? data[idx] : 1'b0;
         in_last[d]   = (idx == data.size() - 1);
         #1;
         if (in_valid[d] && in_ready[d]) idx++;
         stl = out_valid[d] && !ordy;
         pb  = out_bit[d];
         pl  = out_last[d];
         if (out_valid[d] && ordy) begin
            got.push_back(out_bit[d]);
            if (first < 0) begin
               first = cyc;
               bmid  = busy[d];
            end
            if (out_last[d]) begin
               nlast++;
               lastpos = got.size();
               span = cyc - first + 1;
               break;
            end
            if (abort_at > 0 && got.size() == abort_at) break;
         end
         cyc++;
      end
      @(posedge clk); #1;
      in_valid[d]  = 1'b0;
      in_last[d]   = 1'b0;
      out_ready[d] = 1'b1;
   endtask

   task automatic frame(input string tag, input int d, input bit data[$],
                        input int stall, input bit exp[$], input int xspan);
      bit   got[$];
      int   lp;
      int   nl;
      int   sp;
      logic bm;
      run(d, data, stall, 0, got, lp, nl, sp, bm);
      chk({tag, "_seq"}, q2v(got), q2v(exp));
      chk({tag, "_lastpos"}, lp, exp.size());
      chk({tag, "_nlast"}, nl, 1);
      chk({tag, "_busy_mid"}, bm, 1'b1);
      chk({tag, "_busy_end"}, busy[d], 1'b0);
      if (xspan > 0) chk({tag, "_span"}, sp, xspan);
   endtask

   initial begin
      bit   d1[$];
      bit   e[$];
      bit   got[$];
      int   lp;
      int   nl;
      int   sp;
      logic bm;
      int   len;

      rst = 4'hF;
      in_bit = '0;
      in_valid = '0;
      in_last = '0;
      out_ready = 4'hF;
      #1;
      chk("reset_out", {busy, out_valid, in_ready, out_last, out_bit}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 4'h0;
      #1;
      chk("ready_pre_clk", in_ready, 4'h0);
      @(posedge clk); #1;
      chk("ready_post_clk", in_ready, 4'hF);

      d1 = '{1'b1, 1'b0, 1'b1, 1'b1};
      s2q("111000010111", e);
      frame("t1", 0, d1, 0, e, 12);

      s2q("111000011", e);
      frame("t2", 1, d1, 0, e, 9);

      s2q("11101111000111", e);
      frame("t3", 2, '{1'b1}, 0, e, 14);

      s2q("111000010111", e);
      frame("t4", 0, d1, 40, e, 0);

      run(0, d1, 0, 5, got, lp, nl, sp, bm);
      s2q("11100", e);
      chk("t5_prefix", q2v(got), q2v(e));
      chk("t5_prefix_len", got.size(), 5);
      chk("t5_no_last", nl, 0);
      rst[0] = 1'b1;
      #1;
      chk("t5_reset_out",
          {busy[0], out_valid[0], in_ready[0], out_last[0], out_bit[0]}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      @(posedge clk); #1;
      chk("t5_ready", in_ready[0], 1'b1);
      s2q("111000010111", e);
      frame("t5_rerun", 0, d1, 0, e, 12);

      s2q("1110", e);
      frame("t6_a", 3, '{1'b1, 1'b0}, 0, e, 4);
      s2q("11", e);
      frame("t6_b", 3, '{1'b1}, 0, e, 2);

      for (int d = 0; d < 4; d++) begin
         for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            d1 = {};
            for (int i = 0; i < len; i++) d1.push_back(1'($urandom));
            model(d, d1, e);
            frame($sformatf("rnd_d%0d_r%0d", d, r), d, d1,
                  (r % 2) ? 35 : 0, e, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
